ring_counter_timing: RTL and testbench
======================================

// Module: ring_counter_timing
// PURPOSE
//  T-state generator feeding controller_sequencer. Drives the one-hot ring_counter
//  the sequencer decodes, and sizes each instruction's cycle from the sequencer's
//  mode output: 1-byte 6 T, 2-byte 8 T, 3-byte 14 T.
//  Freezes when the sequencer drops enable_ring_counter (HLT); restarts only on clear_req or reset.
//  Also counts retired instructions and flags the halted condition to the front panel.
// PARAMETERS
//  RC_WIDTH  15  ring_counter width, one bit per T-state (T0..T14)
//  COUNT_W   16  width of retired-instruction counter
// PORTS
//  clk                  in   1         system clock, all state on rising edge
//  reset                in   1         asynchronous, active-high
//  mode                 in   2         instruction length from sequencer: 00=1B, 01=2B, 10=3B, 11=reserved
//  enable_ring_counter  in   1         from sequencer; 0 = freeze (HLT)
//  clear_req            in   1         synchronous restart to T0, clears halted
//  ring_counter         out  RC_WIDTH  one-hot T-state to sequencer
//  t_index              out  4         binary index of active T-state (0..14)
//  instr_done           out  1         1-cycle pulse on the cycle the last T-state retires
//  halted               out  1         1 while frozen by enable_ring_counter=0
//  instr_count          out  COUNT_W   retired-instruction count, wraps at 2^COUNT_W
//  step_mode            in   1         [RC_SINGLE_STEP_EN only] 1 = advance on step_req only
//  step_req             in   1         [RC_SINGLE_STEP_EN only] 1-cycle pulse, one T advance
// BEHAVIOUR
//  Reset: ring_counter=1 (T0), t_index=0, instr_done=0, halted=0, instr_count=0.
//  States: RUN, HALT (plus STEP_WAIT with feature). One-hot invariant always holds.
//  RUN: each clk ring_counter advances one bit, same cycle it is decoded (zero latency).
//  Last T-state: T5 for mode 00, T7 for 01, T13 for 10, T14 for 11.
//  mode is sampled only in the current last-T cycle; it is ignored during T0..T3 fetch.
//  At last T: next state T0, instr_done=1 for that cycle, instr_count+1 (wraps to 0).
//  enable_ring_counter=0 in RUN: hold current T-state, go HALT, halted=1 next cycle.
//  No instr_done or count increment on the freezing cycle.
//  HALT: outputs frozen; enable_ring_counter returning to 1 does not resume; only clear_req or reset exits.
//  clear_req (any state): next cycle T0, state RUN, halted=0; instr_count kept; no instr_done.
//  Priority: reset > clear_req > enable_ring_counter=0 > step gating > normal advance.
//  Freeze wins over wrap when enable_ring_counter=0 and at last T simultaneously.
//  Illegal (non-one-hot) ring_counter, e.g. glitch: recover to T0 next cycle.
//  Recovery asserts no instr_done.
//  t_index is a registered-equivalent encode of ring_counter: identical cycle, no lag.
//  Async reset mid-instruction: immediate return to reset values, no partial pulse.
// CONFIGURATION
//  RC_SINGLE_STEP_EN defined: step_mode/step_req ports exist.
//   - step_mode=1: RUN holds at current T until a step_req pulse (STEP_WAIT).
//   - Each step_req advances exactly one T; wrap/instr_done rules unchanged.
//   - step_req while halted is ignored.
//  RC_SINGLE_STEP_EN undefined: ports absent, free-running advance every cycle.
// STRUCTURE
//  Shared package cpu_ctrl_pkg:
//   - MODE_1B/2B/3B/RSV encodings
//   - LAST_T_1B=5, LAST_T_2B=7, LAST_T_3B=13, LAST_T_RSV=14
//   - state enum RC_RUN/RC_HALT/RC_STEP_WAIT
//  One sub-module: onehot_to_index (RC_WIDTH one-hot -> 4-bit index plus valid flag).
//   - valid=0 triggers illegal-state recovery.
// TESTING
//  1. reset, mode=00, enable=1 -> T0..T5 then T0; instr_done at T5; count=1 after 6 clk.
//  2. mode=10 -> 14-cycle loop T0..T13; mode=01 -> 8-cycle loop; count +1 per wrap.
//  3. Drop enable at T4 -> ring_counter stays 0x0010, halted=1.
//     Re-raise enable: still frozen. clear_req -> T0, halted=0.
//  4. enable=0 at T5 of mode 00 -> freeze at T5; no instr_done, count unchanged.
//  5. Assert reset at T9 of mode 10 -> ring_counter=0x0001, count=0 asynchronously.
//     Force ring_counter=0x0003 -> T0 next cycle.
//  6. [RC_SINGLE_STEP_EN] step_mode=1, three step_req pulses -> T0->T3 only.
//     No advance between pulses.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared controller definitions: instruction-length mode encodings, the last
// T-state for each length, and the ring-counter sequencing states.
package cpu_ctrl_pkg;

    // Width of the binary T-state index (T0..T14)
    localparam int RC_IDX_W = 4;

    typedef enum logic [1:0] {
        MODE_1B  = 2'b00,
        MODE_2B  = 2'b01,
        MODE_3B  = 2'b10,
        MODE_RSV = 2'b11
    } mode_t;

    localparam logic [RC_IDX_W-1:0] LAST_T_1B  = 4'd5;
    localparam logic [RC_IDX_W-1:0] LAST_T_2B  = 4'd7;
    localparam logic [RC_IDX_W-1:0] LAST_T_3B  = 4'd13;
    localparam logic [RC_IDX_W-1:0] LAST_T_RSV = 4'd14;

    typedef enum logic [1:0] {
        RC_RUN       = 2'b00,
        RC_HALT      = 2'b01,
        RC_STEP_WAIT = 2'b10
    } rc_state_t;

    // Index of the final T-state of an instruction of the given length
    function automatic logic [RC_IDX_W-1:0] last_t(input mode_t m);
        case (m)
            MODE_1B: last_t = LAST_T_1B;
            MODE_2B: last_t = LAST_T_2B;
            MODE_3B: last_t = LAST_T_3B;
            default: last_t = LAST_T_RSV;
        endcase
    endfunction

endpackage

// File: rtl/ring_counter_timing_onehot_to_index.sv
// One-hot to binary encoder for the T-state ring. valid is low when the input
// has zero or more than one bit set, which the parent uses to force recovery.
module onehot_to_index
    import cpu_ctrl_pkg::*;
#(
    parameter int WIDTH = 15
) (
    input  logic [WIDTH-1:0]    onehot,
    output logic [RC_IDX_W-1:0] index,
    output logic                valid
);

    logic seen;
    logic multi;

    // Encode the set bit position and detect non-one-hot patterns
    always_comb begin
        // NOTE: every output of this block is given a default first so no path leaves it unassigned (no latch).
        index = '0;
        seen  = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                multi = multi | seen;
                seen  = 1'b1;
                index = index | RC_IDX_W'(i);
            end
        end
        valid = seen & ~multi;
    end

endmodule

// File: rtl/ring_counter_timing.sv
// T-state generator for the controller sequencer. Advances a one-hot ring each
// clock, wraps at the last T-state of the current instruction length, counts
// retired instructions and freezes on HLT until clear_req or reset.
// Optional feature: define RC_SINGLE_STEP_EN to add step_mode/step_req
// single-step control (advance one T-state per step_req pulse).
module ring_counter_timing
    import cpu_ctrl_pkg::*;
#(
    parameter int RC_WIDTH = 15,
    parameter int COUNT_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    input  logic                enable_ring_counter,
    input  logic                clear_req,
`ifdef RC_SINGLE_STEP_EN
    input  logic                step_mode,
    input  logic                step_req,
`endif
    output logic [RC_WIDTH-1:0] ring_counter,
    output logic [RC_IDX_W-1:0] t_index,
    output logic                instr_done,
    output logic                halted,
    output logic [COUNT_W-1:0]  instr_count
);

    localparam logic [RC_WIDTH-1:0] T0_ONEHOT = RC_WIDTH'(1);
    localparam logic [RC_IDX_W-1:0] TOP_IDX   = RC_IDX_W'(RC_WIDTH - 1);

    rc_state_t           state_q, state_d;
    logic [RC_WIDTH-1:0] rc_q, rc_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic [RC_IDX_W-1:0] idx;
    logic                idx_valid;
    logic                at_last;
    logic                advance_ok;
    rc_state_t           run_state;

    onehot_to_index #(.WIDTH(RC_WIDTH)) u_encode (
        .onehot (rc_q),
        .index  (idx),
        .valid  (idx_valid)
    );

`ifdef RC_SINGLE_STEP_EN
    assign advance_ok = ~step_mode | step_req;
    assign run_state  = step_mode ? RC_STEP_WAIT : RC_RUN;
`else
    assign advance_ok = 1'b1;
    assign run_state  = RC_RUN;
`endif

    // Mode only matters at the last T-state; T14 always wraps so the ring never shifts out
    assign at_last = (idx == last_t(mode_t'(mode))) || (idx == TOP_IDX);

    // Next ring position, sequencing state, retire pulse and count
    always_comb begin
        rc_d       = rc_q;
        state_d    = state_q;
        count_d    = count_q;
        instr_done = 1'b0;
        if (clear_req) begin
            rc_d    = T0_ONEHOT;
            state_d = RC_RUN;
        end else if (!idx_valid) begin
            rc_d = T0_ONEHOT;
        end else begin
            case (state_q)
                RC_HALT: begin
                    // Frozen until clear_req or reset
                end
                default: begin
                    if (!enable_ring_counter) begin
                        state_d = RC_HALT;
                    end else begin
                        state_d = run_state;
                        if (advance_ok) begin
                            if (at_last) begin
                                rc_d       = T0_ONEHOT;
                                instr_done = 1'b1;
                                count_d    = count_q + 1'b1;
                            end else begin
                                rc_d = rc_q << 1;
                            end
                        end
                    end
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            rc_q    <= T0_ONEHOT;
            state_q <= RC_RUN;
            count_q <= '0;
        end else begin
            rc_q    <= rc_d;
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign ring_counter = rc_q;
    assign t_index      = idx;
    assign halted       = (state_q == RC_HALT);
    assign instr_count  = count_q;

endmodule

// File: tb/tb_ring_counter_timing.sv
// Directed self-checking bench for ring_counter_timing. Inputs change 2 ns
// after each rising edge; outputs are checked at that same point.
`timescale 1ns/1ps
module tb_ring_counter_timing;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        enable_ring_counter;
    logic        clear_req;
`ifdef RC_SINGLE_STEP_EN
    logic        step_mode;
    logic        step_req;
`endif
    logic [14:0] ring_counter;
    logic [3:0]  t_index;
    logic        instr_done;
    logic        halted;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;

    ring_counter_timing #(.RC_WIDTH(15), .COUNT_W(16)) dut (
        .clk                 (clk),
        .reset               (reset),
        .mode                (mode),
        .enable_ring_counter (enable_ring_counter),
        .clear_req           (clear_req),
`ifdef RC_SINGLE_STEP_EN
        .step_mode           (step_mode),
        .step_req            (step_req),
`endif
        .ring_counter        (ring_counter),
        .t_index             (t_index),
        .instr_done          (instr_done),
        .halted              (halted),
        .instr_count         (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Run one full instruction of length len starting at T0
    task automatic run_loop(input logic [1:0] m, input int len, input int base_count);
        mode = m;
        for (int i = 0; i < len; i++) begin
            check($sformatf("m%0d_rc_T%0d", m, i), 32'(ring_counter), 32'(15'(1) << i));
            check($sformatf("m%0d_idx_T%0d", m, i), 32'(t_index), 32'(i));
            check($sformatf("m%0d_done_T%0d", m, i), 32'(instr_done), 32'(i == len - 1));
            tick();
        end
        check($sformatf("m%0d_wrap_rc", m), 32'(ring_counter), 32'h1);
        check($sformatf("m%0d_count", m), 32'(instr_count), 32'(base_count + 1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset               = 1'b1;
        mode                = 2'b00;
        enable_ring_counter = 1'b1;
        clear_req           = 1'b0;
`ifdef RC_SINGLE_STEP_EN
        step_mode           = 1'b0;
        step_req            = 1'b0;
`endif
        #12;
        check("rst_rc", 32'(ring_counter), 32'h1);
        check("rst_idx", 32'(t_index), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_count", 32'(instr_count), 32'h0);
        reset = 1'b0;
        #1;
        check("rst_done", 32'(instr_done), 32'h0);
        tick();
        // The first edge after release advances to T1; re-align on T0
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;

        // Instruction lengths: 6, 14, 8, 15 T-states
        run_loop(2'b00, 6, 0);
        run_loop(2'b10, 14, 1);
        run_loop(2'b01, 8, 2);
        run_loop(2'b11, 15, 3);

        // HLT at T4: frozen, re-enable does not resume, clear_req restarts
        mode = 2'b00;
        tick(4);
        check("hlt_T4_rc", 32'(ring_counter), 32'h0010);
        enable_ring_counter = 1'b0;
        #1 check("hlt_freeze_done", 32'(instr_done), 32'h0);
        tick();
        check("hlt_rc", 32'(ring_counter), 32'h0010);
        check("hlt_halted", 32'(halted), 32'h1);
        enable_ring_counter = 1'b1;
        tick(2);
        check("hlt_reen_rc", 32'(ring_counter), 32'h0010);
        check("hlt_reen_halted", 32'(halted), 32'h1);
        check("hlt_reen_done", 32'(instr_done), 32'h0);
        clear_req = 1'b1;
        #1 check("clr_done", 32'(instr_done), 32'h0);
        tick();
        clear_req = 1'b0;
        check("clr_rc", 32'(ring_counter), 32'h1);
        check("clr_halted", 32'(halted), 32'h0);
        check("clr_count", 32'(instr_count), 32'h4);

        // Freeze wins over wrap at T5 of a 1-byte instruction
        tick(5);
        check("t5_rc", 32'(ring_counter), 32'h0020);
        check("t5_done", 32'(instr_done), 32'h1);
        enable_ring_counter = 1'b0;
        #1 check("t5_freeze_done", 32'(instr_done), 32'h0);
        tick();
        check("t5_frz_rc", 32'(ring_counter), 32'h0020);
        check("t5_frz_halted", 32'(halted), 32'h1);
        check("t5_frz_count", 32'(instr_count), 32'h4);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        enable_ring_counter = 1'b1;
        check("t5_clr_rc", 32'(ring_counter), 32'h1);

        // Asynchronous reset at T9 of a 3-byte instruction
        mode = 2'b10;
        tick(9);
        check("t9_rc", 32'(ring_counter), 32'h0200);
        #1 reset = 1'b1;
        #1;
        check("areset_rc", 32'(ring_counter), 32'h1);
        check("areset_count", 32'(instr_count), 32'h0);
        check("areset_done", 32'(instr_done), 32'h0);
        #1 reset = 1'b0;
        tick();
        check("post_reset_rc", 32'(ring_counter), 32'h0002);

        // Illegal ring pattern recovers to T0 without a retire pulse
        force dut.rc_q = 15'h0003;
        #1;
        check("illegal_rc", 32'(ring_counter), 32'h0003);
        check("illegal_done", 32'(instr_done), 32'h0);
        release dut.rc_q;
        tick();
        check("recover_rc", 32'(ring_counter), 32'h1);
        check("recover_count", 32'(instr_count), 32'h0);

`ifdef RC_SINGLE_STEP_EN
        // Single-step: hold at T0, then three pulses advance to T3
        mode = 2'b00;
        step_mode = 1'b1;
        tick(2);
        check("step_hold_rc", 32'(ring_counter), 32'h1);
        for (int s = 1; s <= 3; s++) begin
            step_req = 1'b1;
            tick();
            step_req = 1'b0;
            check($sformatf("step%0d_rc", s), 32'(ring_counter), 32'(15'(1) << s));
            tick();
            check($sformatf("step%0d_hold_rc", s), 32'(ring_counter), 32'(15'(1) << s));
        end
        enable_ring_counter = 1'b0;
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("step_halted_rc", 32'(ring_counter), 32'h0008);
        check("step_halted", 32'(halted), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
